// File: rtl/regfile_scoreboard.sv
// ID-stage 32x32 register file with same-cycle writeback bypass and a
// per-register pending-write scoreboard that raises stall_req on unresolved reads.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en_1,
  input  logic [ADDR_W-1:0] read_addr_1,
  output logic [DATA_W-1:0] read_data_1,
  input  logic              read_en_2,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall_req,
  output logic              pending_any
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                wb_live;
  logic                byp_hit_1;
  logic                byp_hit_2;
  logic                stall_1;
  logic                stall_2;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = {NUM_REGS{1'b0}};
    v[addr] = 1'b1;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] read_mux(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] bypass_data
  );
    logic [DATA_W-1:0] r;
    if (!en || (addr == ZERO_ADDR)) begin
      r = {DATA_W{1'b0}};
    end else if (hit) begin
      r = bypass_data;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Read muxing, bypass detection and hazard detection for both operand ports.
  // The bypass is gated by rst_n so outputs read zero while reset is held.
  always_comb begin
    wb_live     = wb_en && rst_n;
    byp_hit_1   = wb_live && (wb_addr == read_addr_1);
    byp_hit_2   = wb_live && (wb_addr == read_addr_2);
    read_data_1 = read_mux(read_en_1, read_addr_1, regs_q[read_addr_1], byp_hit_1, wb_data);
    read_data_2 = read_mux(read_en_2, read_addr_2, regs_q[read_addr_2], byp_hit_2, wb_data);
    stall_1     = read_en_1 && (read_addr_1 != ZERO_ADDR) && pending_q[read_addr_1] && !byp_hit_1;
    stall_2     = read_en_2 && (read_addr_2 != ZERO_ADDR) && pending_q[read_addr_2] && !byp_hit_2;
    stall_req   = stall_1 || stall_2;
  end

  // Scoreboard next state: wb clears, then issue sets so a younger issuer wins.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = {NUM_REGS{1'b0}};
    end else begin
      if (wb_en && (wb_addr != ZERO_ADDR)) begin
        pending_d = pending_d & ~onehot(wb_addr);
      end else begin
        pending_d = pending_d;
      end
      if (issue_en && (issue_addr != ZERO_ADDR)) begin
        pending_d = pending_d | onehot(issue_addr);
      end else begin
        pending_d = pending_d;
      end
    end
  end

  // Register array storage; index 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en && (wb_addr != ZERO_ADDR)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Pending-write scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= {NUM_REGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_any = |pending_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- ID-stage general-purpose register file for the MIPS core, 32 x 32-bit.
- Consumes the read-enable/read-address and write-enable/write-address signals produced by the instruction decoder's register-address generator, and returns operand data.
- Accepts writeback from WB.
- Keeps a per-register pending-write scoreboard for long-latency producers (loads, MFC0). A read of an unresolved register raises a stall.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers, including $zero

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- read_en_1  input  1  operand 1 read request
- read_addr_1  input  ADDR_W  operand 1 register index
- read_data_1  output  DATA_W  operand 1 value (combinational)
- read_en_2  input  1  operand 2 read request
- read_addr_2  input  ADDR_W  operand 2 register index
- read_data_2  output  DATA_W  operand 2 value (combinational)
- issue_en  input  1  the instruction leaving ID is a long-latency writer
- issue_addr  input  ADDR_W  destination register of that instruction
- wb_en  input  1  writeback valid
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback value
- flush  input  1  pipeline flush (exception/eret); discards outstanding claims
- stall_req  output  1  ID must hold; an enabled operand is pending
- pending_any  output  1  at least one scoreboard bit set (registered view)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 32 registers clear to 0 and all pending bits clear to 0.
  - Consequently read_data_1/2 = 0, stall_req = 0, pending_any = 0.
  - Reset asserted mid-operation discards any writeback or issue occurring in the same cycle.
- Register $zero:
  - Reads of index 0 return 0.
  - Writes to index 0 are dropped.
  - Issue to index 0 never sets a pending bit.
- Read, per port:
  - en = 0 -> data = 0.
  - addr = 0 -> data = 0.
  - wb_en = 1 and wb_addr = addr (nonzero) -> data = wb_data (same-cycle write-through bypass).
  - Otherwise -> data = the stored register value.
  - Zero latency, purely combinational from inputs and state.
- Write: on the rising edge with wb_en = 1 and wb_addr != 0, reg[wb_addr] <= wb_data.
- Scoreboard, evaluated per rising edge:
  - flush = 1 -> all pending bits cleared; issue_en ignored that cycle. The writeback still commits data and, if its register is pending, that bit is cleared anyway.
  - Otherwise, wb_en = 1 with wb_addr != 0 clears pending[wb_addr].
  - Otherwise, issue_en = 1 with issue_addr != 0 sets pending[issue_addr].
  - Same register issued and written back in the same cycle: set wins. The issuing instruction is younger, so the register stays pending.
  - Issue to a register already pending keeps it set (no counting). A second outstanding writer to the same register is legal only because the earlier one retires first in order.
- stall_req:
  - Asserted when either port has en = 1, addr != 0, pending[addr] = 1, and not (wb_en = 1 and wb_addr = addr). A same-cycle writeback resolves the hazard through the bypass.
  - Combinational.
  - While stall_req is high the upstream holds issue_en = 0.
- pending_any: OR of the pending bits; directly register-derived, with no combinational path from the inputs.
- No X propagation: all outputs are defined for every input combination after reset.

Test Plan:
1. Reset, then read ports 1/2 at addr 5 and 31 with en = 1 -> both data 0, stall_req 0, pending_any 0.
2. wb_en = 1, wb_addr = 8, wb_data = 0xDEADBEEF while read_addr_1 = 8 -> read_data_1 = 0xDEADBEEF the same cycle. Next cycle, with wb_en = 0, still 0xDEADBEEF.
3. Write wb_addr = 0, wb_data = 0x12345678, then read addr 0 -> 0. issue_en with issue_addr = 0 -> pending_any stays 0.
4. issue_en with issue_addr = 9, then next cycle read_addr_2 = 9 with en = 1 -> stall_req = 1.
   - Hold until wb_en, wb_addr = 9, wb_data = 0xCAFE0001 -> stall_req = 0 that cycle, read_data_2 = 0xCAFE0001.
   - Cycle after: pending_any = 0.
5. Same cycle: issue_addr = 4 and wb_addr = 4 -> next cycle pending[4] set (a read of 4 stalls) and reg[4] holds wb_data. Repeat with read_en_1 = 0 -> stall_req = 0.
6. Set pending on 3, 7 and 12, assert flush together with issue_addr = 15 -> next cycle pending_any = 0 and no stall on 3/7/12/15. Then assert rst_n = 0 asynchronously mid-cycle -> registers read 0 immediately.
